mem_port_arbiter: RTL and testbench

- Shares one unified single-port memory between the instruction-fetch requester and the load/store requester of the MIPS core.
- Serialises the two requesters so that at most one memory transaction is outstanding at a time.
- Drives a stall to the core (PC and register-file write enable) while any request is unserved.
- Sits between the core datapath (PC/instruction path and ALU-result/data path) and the memory macro.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter_timeout_cnt.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state
// encoding, requester identifiers and default bus widths.
package mips_pkg;

  localparam int ADDR_W_DEF  = 13;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  // Requester that is not the given one.
  function automatic req_id_e other_req(input req_id_e id);
    other_req = (id == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of core-side and memory-side signals around the port arbiter.
// The master modport is the arbiter's view; slave is the view of the
// core and memory macro that surround it.
interface mem_port_arbiter_if
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  // Instruction-fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;
  // Load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  // Memory macro
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;
  // Core control
  logic              core_stall;
  logic              err;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_done, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, core_stall, err
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_done, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, core_stall, err
  );
endinterface

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Transaction watchdog: clearable counter that saturates at TIMEOUT-1
// and flags expiry while it sits there.
module arb_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up to the saturation point.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and
// load/store. One transaction outstanding at a time; data beats fetch on
// contention unless ARB_RR_EN is defined, in which case the requester not
// served last wins. Completion is handed straight to a waiting requester
// without an idle bubble. A transaction without mem_done for TIMEOUT
// cycles is abandoned and raises the sticky err flag.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_port_arbiter_if.master bus
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic              issue_s;
  req_id_e           issue_id_s;
  req_id_e           contend_id_s;
  logic              busy_s;
  logic              expired_s;
  logic              timeout_s;
  logic              i_done_s;
  logic              d_done_s;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              err_q;

  assign busy_s    = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign timeout_s = busy_s && !bus.mem_done && expired_s;

`ifdef ARB_RR_EN
  req_id_e last_served_q;

  // Remember which requester was issued most recently.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_served_q <= REQ_I;
    end else if (issue_s) begin
      last_served_q <= issue_id_s;
    end else begin
      last_served_q <= last_served_q;
    end
  end

  assign contend_id_s = other_req(last_served_q);
`else
  assign contend_id_s = REQ_D;
`endif

  // Watchdog restarts on every issue and only runs while a transaction is open.
  arb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (issue_s || !busy_s),
    .en_i      (busy_s),
    .expired_o (expired_s)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and issue decision. After a timeout the arbiter stops
  // issuing so the stranded requester stays stalled until reset.
  always_comb begin
    state_d    = state_q;
    issue_s    = 1'b0;
    issue_id_s = REQ_I;
    case (state_q)
      IDLE: begin
        if (err_q) begin
          state_d = IDLE;
        end else if (bus.i_req && bus.d_req) begin
          issue_s    = 1'b1;
          issue_id_s = contend_id_s;
        end else if (bus.d_req) begin
          issue_s    = 1'b1;
          issue_id_s = REQ_D;
        end else if (bus.i_req) begin
          issue_s    = 1'b1;
          issue_id_s = REQ_I;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_I: begin
        if (bus.mem_done) begin
          if (bus.d_req) begin
            issue_s    = 1'b1;
            issue_id_s = REQ_D;
          end else begin
            state_d = IDLE;
          end
        end else if (expired_s) begin
          state_d = IDLE;
        end else begin
          state_d = BUSY_I;
        end
      end
      BUSY_D: begin
        if (bus.mem_done) begin
          if (bus.i_req) begin
            issue_s    = 1'b1;
            issue_id_s = REQ_I;
          end else begin
            state_d = IDLE;
          end
        end else if (expired_s) begin
          state_d = IDLE;
        end else begin
          state_d = BUSY_D;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (issue_s) begin
      state_d = (issue_id_s == REQ_D) ? BUSY_D : BUSY_I;
    end else begin
      state_d = state_d;
    end
  end

  // Memory-side registers: loaded from the winner on issue, dropped on return to IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (issue_s) begin
      mem_req_q <= 1'b1;
      if (issue_id_s == REQ_D) begin
        mem_we_q    <= bus.d_we;
        mem_addr_q  <= bus.d_addr;
        mem_wdata_q <= bus.d_wdata;
      end else begin
        mem_we_q    <= 1'b0;
        mem_addr_q  <= bus.i_addr;
        mem_wdata_q <= '0;
      end
    end else if (state_d == IDLE) begin
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      mem_req_q <= mem_req_q;
      mem_we_q  <= mem_we_q;
    end
  end

  // Sticky timeout flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q || timeout_s;
    end
  end

  // Completion pulses, read-data steering and stall, all combinational.
  always_comb begin
    i_done_s       = (state_q == BUSY_I) && bus.mem_done && !rst_i;
    d_done_s       = (state_q == BUSY_D) && bus.mem_done && !rst_i;
    bus.i_done     = i_done_s;
    bus.d_done     = d_done_s;
    bus.i_rdata    = i_done_s ? bus.mem_rdata : '0;
    bus.d_rdata    = d_done_s ? bus.mem_rdata : '0;
    bus.core_stall = (bus.i_req && !i_done_s) || (bus.d_req && !d_done_s);
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, store, second
// contention, back-to-back fetches, timeout and reset mid-transaction.
module tb_mem_port_arbiter;
  import mips_pkg::*;

`ifdef ARB_RR_EN
  localparam logic RR_FIRST_I = 1'b1;
`else
  localparam logic RR_FIRST_I = 1'b0;
`endif

  logic clk_i;
  logic rst_i;
  int   checks;
  int   failures;

  mem_port_arbiter_if #(.ADDR_W(13), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(13), .DATA_W(32), .TIMEOUT(64)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic first_i;
    checks      = 0;
    failures    = 0;
    first_i     = RR_FIRST_I;
    rst_i       = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    step();
    step();
    rst_i = 1'b0;
    settle();
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_stall", 32'(bus.core_stall), 32'd0);

    // Fetch only, memory answers two cycles after issue
    bus.i_req = 1'b1; bus.i_addr = 13'h004;
    settle();
    chk("f_stall_req", 32'(bus.core_stall), 32'd1);
    chk("f_mem_req_pre", 32'(bus.mem_req), 32'd0);
    step();
    chk("f_mem_req", 32'(bus.mem_req), 32'd1);
    chk("f_mem_addr", 32'(bus.mem_addr), 32'h004);
    chk("f_mem_we", 32'(bus.mem_we), 32'd0);
    step();
    chk("f_no_done_early", 32'(bus.i_done), 32'd0);
    step();
    bus.mem_done = 1'b1; bus.mem_rdata = 32'h2008000A;
    settle();
    chk("f_i_done", 32'(bus.i_done), 32'd1);
    chk("f_i_rdata", bus.i_rdata, 32'h2008000A);
    chk("f_stall_done", 32'(bus.core_stall), 32'd0);
    step();
    bus.mem_done = 1'b0; bus.i_req = 1'b0;
    settle();
    chk("f_stall_after", 32'(bus.core_stall), 32'd0);
    chk("f_mem_req_after", 32'(bus.mem_req), 32'd0);
    chk("f_i_done_after", 32'(bus.i_done), 32'd0);

    // Simultaneous fetch and load: data first, handoff without a bubble
    bus.i_req = 1'b1; bus.i_addr = 13'h008;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 13'h010;
    step();
    chk("s_first_addr", 32'(bus.mem_addr), 32'h010);
    step();
    bus.mem_done = 1'b1; bus.mem_rdata = 32'h11111111;
    settle();
    chk("s_d_done", 32'(bus.d_done), 32'd1);
    chk("s_d_rdata", bus.d_rdata, 32'h11111111);
    chk("s_i_done_quiet", 32'(bus.i_done), 32'd0);
    chk("s_stall_pending", 32'(bus.core_stall), 32'd1);
    step();
    bus.mem_done = 1'b0; bus.d_req = 1'b0;
    settle();
    chk("s_handoff_req", 32'(bus.mem_req), 32'd1);
    chk("s_handoff_addr", 32'(bus.mem_addr), 32'h008);
    bus.mem_done = 1'b1; bus.mem_rdata = 32'h22222222;
    settle();
    chk("s_i_done", 32'(bus.i_done), 32'd1);
    chk("s_i_rdata", bus.i_rdata, 32'h22222222);
    step();
    bus.mem_done = 1'b0; bus.i_req = 1'b0;
    settle();
    chk("s_idle", 32'(bus.mem_req), 32'd0);

    // Store to the top word
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 13'h1FFF; bus.d_wdata = 32'hDEADBEEF;
    step();
    chk("w_mem_we", 32'(bus.mem_we), 32'd1);
    chk("w_mem_addr", 32'(bus.mem_addr), 32'h1FFF);
    chk("w_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    step();
    bus.mem_done = 1'b1;
    settle();
    chk("w_d_done", 32'(bus.d_done), 32'd1);
    step();
    bus.mem_done = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    settle();
    chk("w_d_done_once", 32'(bus.d_done), 32'd0);
    chk("w_mem_we_off", 32'(bus.mem_we), 32'd0);

    // Contention after a data service
    bus.i_req = 1'b1; bus.i_addr = 13'h020;
    bus.d_req = 1'b1; bus.d_addr = 13'h030;
    step();
    chk("c_first_addr", 32'(bus.mem_addr), first_i ? 32'h020 : 32'h030);
    bus.mem_done = 1'b1; bus.mem_rdata = 32'h33333333;
    settle();
    chk("c_first_i_done", 32'(bus.i_done), 32'(first_i));
    chk("c_first_d_done", 32'(bus.d_done), 32'(!first_i));
    step();
    bus.mem_done = 1'b0;
    bus.i_req = !first_i; bus.d_req = first_i;
    settle();
    chk("c_second_addr", 32'(bus.mem_addr), first_i ? 32'h030 : 32'h020);
    bus.mem_done = 1'b1;
    settle();
    chk("c_second_i_done", 32'(bus.i_done), 32'(!first_i));
    chk("c_second_d_done", 32'(bus.d_done), 32'(first_i));
    step();
    bus.mem_done = 1'b0; bus.i_req = 1'b0; bus.d_req = 1'b0;
    settle();
    chk("c_idle", 32'(bus.mem_req), 32'd0);

    // Back-to-back fetches with the fastest memory
    bus.i_req = 1'b1; bus.i_addr = 13'h040;
    step();
    chk("b_addr0", 32'(bus.mem_addr), 32'h040);
    bus.mem_done = 1'b1; bus.mem_rdata = 32'h44444444;
    settle();
    chk("b_done0", 32'(bus.i_done), 32'd1);
    step();
    bus.mem_done = 1'b0; bus.i_addr = 13'h044;
    settle();
    chk("b_gap_done", 32'(bus.i_done), 32'd0);
    chk("b_gap_req", 32'(bus.mem_req), 32'd0);
    step();
    chk("b_addr1", 32'(bus.mem_addr), 32'h044);
    chk("b_req1", 32'(bus.mem_req), 32'd1);
    bus.mem_done = 1'b1; bus.mem_rdata = 32'h55555555;
    settle();
    chk("b_done1", 32'(bus.i_done), 32'd1);
    chk("b_rdata1", bus.i_rdata, 32'h55555555);
    step();
    bus.mem_done = 1'b0; bus.i_req = 1'b0;
    settle();
    chk("b_no_dup", 32'(bus.i_done), 32'd0);

    // Timeout: load never answered
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 13'h050;
    step();
    chk("t_issue", 32'(bus.mem_req), 32'd1);
    repeat (63) step();
    chk("t_req_63", 32'(bus.mem_req), 32'd1);
    chk("t_err_63", 32'(bus.err), 32'd0);
    step();
    chk("t_err_64", 32'(bus.err), 32'd1);
    chk("t_req_64", 32'(bus.mem_req), 32'd0);
    chk("t_stall_64", 32'(bus.core_stall), 32'd1);
    repeat (5) step();
    chk("t_err_hold", 32'(bus.err), 32'd1);
    chk("t_no_reissue", 32'(bus.mem_req), 32'd0);
    chk("t_no_done", 32'(bus.d_done), 32'd0);
    bus.d_req = 1'b0;
    step();
    chk("t_err_sticky", 32'(bus.err), 32'd1);

    // Reset clears err, then reset in the middle of a fetch
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    settle();
    chk("r_err_clear", 32'(bus.err), 32'd0);
    bus.i_req = 1'b1; bus.i_addr = 13'h060;
    step();
    chk("r_busy", 32'(bus.mem_req), 32'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; bus.i_req = 1'b0;
    bus.mem_done = 1'b1; bus.mem_rdata = 32'h66666666;
    settle();
    chk("r_i_done", 32'(bus.i_done), 32'd0);
    chk("r_i_rdata", bus.i_rdata, 32'd0);
    chk("r_mem_req", 32'(bus.mem_req), 32'd0);
    chk("r_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("r_mem_we", 32'(bus.mem_we), 32'd0);
    chk("r_stall", 32'(bus.core_stall), 32'd0);
    step();
    bus.mem_done = 1'b0;
    settle();
    chk("r_still_idle", 32'(bus.mem_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
